dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
//==============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-requester arbiter in front of a single-port data memory.
//            Define DMEM_ARB_RR_EN for round-robin; otherwise m0 has priority.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int RD_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic        m0_rerr,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic        m1_rerr,

    output logic [31:0] rdata,

    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_mask,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    input  logic [31:0] mem_read_data,
    input  logic        mem_read_valid
);

    localparam logic [7:0] TIMEOUT_CNT = RD_TIMEOUT[7:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic        owner_q, owner_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic        sel;
    logic        sel_we;

`ifdef DMEM_ARB_RR_EN
    logic        rr_q, rr_d;

    // rr_q names the port that wins the next simultaneous request.
    always_comb begin
        sel = m1_req;
        if (m0_req && m1_req) begin
            sel = rr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (state_q == IDLE && (m0_req || m1_req) && !rst) begin
            rr_d = ~sel;
        end
    end
`else
    always_comb begin
        sel = !m0_req;
    end
`endif

    assign sel_we = sel ? m1_we : m0_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wmask_q <= 4'd0;
            owner_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        wmask_d          = wmask_q;
        owner_d          = owner_q;
        cnt_d            = cnt_q;
        m0_gnt           = 1'b0;
        m1_gnt           = 1'b0;
        m0_rvalid        = 1'b0;
        m1_rvalid        = 1'b0;
        m0_rerr          = 1'b0;
        m1_rerr          = 1'b0;
        rdata            = 32'd0;
        mem_address      = 32'd0;
        mem_write_data   = 32'd0;
        mem_write_mask   = 4'd0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;

        // All outputs stay quiet while reset is held, even mid-access.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        m0_gnt  = !sel;
                        m1_gnt  = sel;
                        owner_d = sel;
                        addr_d  = sel ? m1_addr  : m0_addr;
                        wdata_d = sel ? m1_wdata : m0_wdata;
                        wmask_d = sel ? m1_wmask : m0_wmask;
                        state_d = sel_we ? WR : RD;
                        cnt_d   = sel_we ? 8'd0 : 8'd1;
                    end
                end
                WR: begin
                    mem_address      = addr_q;
                    mem_write_data   = wdata_q;
                    mem_write_mask   = wmask_q;
                    mem_write_enable = 1'b1;
                    state_d          = IDLE;
                end
                RD: begin
                    mem_address     = addr_q;
                    mem_write_data  = wdata_q;
                    mem_write_mask  = wmask_q;
                    mem_read_enable = !mem_read_valid;
                    if (mem_read_valid) begin
                        m0_rvalid = !owner_q;
                        m1_rvalid = owner_q;
                        rdata     = mem_read_data;
                        state_d   = IDLE;
                        cnt_d     = 8'd0;
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        m0_rvalid = !owner_q;
                        m1_rvalid = owner_q;
                        m0_rerr   = !owner_q;
                        m1_rerr   = owner_q;
                        state_d   = IDLE;
                        cnt_d     = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//==============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_rerr;
    logic [31:0] m0_addr, m0_wdata;
    logic [3:0]  m0_wmask;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_rerr;
    logic [31:0] m1_addr, m1_wdata;
    logic [3:0]  m1_wmask;
    logic [31:0] rdata;
    logic [31:0] mem_address, mem_write_data;
    logic [3:0]  mem_write_mask;
    logic        mem_write_enable, mem_read_enable;
    logic [31:0] mem_read_data;
    logic        mem_read_valid;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.RD_TIMEOUT(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .m0_req           (m0_req),
        .m0_we            (m0_we),
        .m0_addr          (m0_addr),
        .m0_wdata         (m0_wdata),
        .m0_wmask         (m0_wmask),
        .m0_gnt           (m0_gnt),
        .m0_rvalid        (m0_rvalid),
        .m0_rerr          (m0_rerr),
        .m1_req           (m1_req),
        .m1_we            (m1_we),
        .m1_addr          (m1_addr),
        .m1_wdata         (m1_wdata),
        .m1_wmask         (m1_wmask),
        .m1_gnt           (m1_gnt),
        .m1_rvalid        (m1_rvalid),
        .m1_rerr          (m1_rerr),
        .rdata            (rdata),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_mask   (mem_write_mask),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_read_data    (mem_read_data),
        .mem_read_valid   (mem_read_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1ns after the edge, outputs are checked 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [1:0] exp_gnt [4];

    initial begin
        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wmask = 4'd0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wmask = 4'd0;
        mem_read_data = 32'd0;
        mem_read_valid = 1'b0;

`ifdef DMEM_ARB_RR_EN
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
`else
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b01;
`endif

        // Reset: requests ignored, everything quiet
        tick();
        tick();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h4;
        m1_req = 1'b1;
        settle();
        check("rst_gnt",   {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check("rst_en",    {30'd0, mem_write_enable, mem_read_enable}, 32'd0);
        check("rst_rvld",  {28'd0, m1_rerr, m0_rerr, m1_rvalid, m0_rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_addr",  mem_address, 32'd0);
        tick();
        rst = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        settle();
        check("idle_noreq", {28'd0, m1_gnt, m0_gnt, mem_write_enable, mem_read_enable}, 32'd0);

        // m0 write 0x10
        tick();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hA1B2C3D4; m0_wmask = 4'hF;
        settle();
        check("wr_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        check("wr_gnt_nowe", {31'd0, mem_write_enable}, 32'd0);
        tick();
        m0_req = 1'b0;
        settle();
        check("wr_we",    {30'd0, mem_write_enable, mem_read_enable}, 32'd2);
        check("wr_addr",  mem_address, 32'h10);
        check("wr_data",  mem_write_data, 32'hA1B2C3D4);
        check("wr_mask",  {28'd0, mem_write_mask}, 32'hF);
        tick();
        settle();
        check("wr_idle", {30'd0, mem_write_enable, mem_read_enable}, 32'd0);
        check("wr_idle_addr", mem_address, 32'd0);

        // m1 read 0x10, data returned at N+2
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10;
        settle();
        check("rd_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        tick();
        m1_req = 1'b0;
        settle();
        check("rd_re",   {30'd0, mem_write_enable, mem_read_enable}, 32'd1);
        check("rd_addr", mem_address, 32'h10);
        check("rd_norv", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        tick();
        mem_read_valid = 1'b1; mem_read_data = 32'hA1B2C3D4;
        settle();
        check("rd_rvalid", {28'd0, m1_rerr, m0_rerr, m1_rvalid, m0_rvalid}, 32'd2);
        check("rd_rdata",  rdata, 32'hA1B2C3D4);
        check("rd_re_off", {31'd0, mem_read_enable}, 32'd0);
        tick();
        mem_read_valid = 1'b0; mem_read_data = 32'd0;
        settle();
        check("rd_idle", {28'd0, m1_rvalid, m0_rvalid, mem_write_enable, mem_read_enable}, 32'd0);

        // Simultaneous writes, four grants
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h11111111; m0_wmask = 4'h3;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h30; m1_wdata = 32'h22222222; m1_wmask = 4'hC;
        for (int g = 0; g < 4; g++) begin
            settle();
            check($sformatf("arb_gnt%0d", g), {30'd0, m1_gnt, m0_gnt}, {30'd0, exp_gnt[g]});
            tick();
            settle();
            check($sformatf("arb_addr%0d", g), mem_address, exp_gnt[g][1] ? 32'h30 : 32'h20);
            check($sformatf("arb_mask%0d", g), {28'd0, mem_write_mask}, exp_gnt[g][1] ? 32'hC : 32'h3);
            tick();
        end
        m0_req = 1'b0; m1_req = 1'b0;

        // m0 read timeout; stale bus data must not leak onto rdata
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h44;
        mem_read_data = 32'hDEADBEEF;
        settle();
        check("to_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        tick();
        m0_req = 1'b0;
        for (int k = 1; k < 8; k++) begin
            settle();
            check($sformatf("to_wait%0d", k), {29'd0, m1_rvalid, m0_rvalid, mem_read_enable}, 32'd1);
            tick();
        end
        settle();
        check("to_rvalid", {28'd0, m1_rerr, m0_rerr, m1_rvalid, m0_rvalid}, 32'd5);
        check("to_rdata",  rdata, 32'd0);
        tick();
        settle();
        check("to_idle", {28'd0, m1_rvalid, m0_rvalid, mem_write_enable, mem_read_enable}, 32'd0);

        // Reset during RD aborts the read
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h80;
        settle();
        check("ra_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        tick();
        m1_req = 1'b0;
        rst = 1'b1;
        settle();
        check("ra_quiet", {28'd0, m1_rvalid, m0_rvalid, mem_write_enable, mem_read_enable}, 32'd0);
        tick();
        rst = 1'b0;
        mem_read_valid = 1'b1; mem_read_data = 32'h55AA55AA;
        settle();
        check("ra_norv", {28'd0, m1_rerr, m0_rerr, m1_rvalid, m0_rvalid}, 32'd0);
        check("ra_idle_addr", mem_address, 32'd0);
        tick();
        mem_read_valid = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8;
        settle();
        check("ra_next_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        tick();
        m0_req = 1'b0;
        settle();
        check("ra_next_addr", mem_address, 32'h8);
        tick();
        mem_read_valid = 1'b1; mem_read_data = 32'h0BADF00D;
        settle();
        check("ra_next_rv", {28'd0, m1_rerr, m0_rerr, m1_rvalid, m0_rvalid}, 32'd1);
        check("ra_next_data", rdata, 32'h0BADF00D);
        tick();
        mem_read_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
